// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounced input stage.
package debounce_pkg;

    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_STABLE_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } state_e;

endpackage : debounce_pkg

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for an asynchronous level; only the last stage is meant to be consumed.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : sync_chain

// File: rtl/debounce_sync.sv
// Synchronizes a raw input and accepts a new level only after it has been stable for
// STABLE_CYCLES consecutive synchronized samples; emits one-cycle rise/fall pulses.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (d_in),
        .q     (s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // A candidate level restarts its count from 1 whenever it is interrupted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LO: begin
                if (s) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_HI: begin
                if (!s) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            CHK_LO: begin
                if (s) begin
                    state_d = IDLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LO;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
            end
        endcase
        q_d = (state_d == IDLE_HI) || (state_d == CHK_LO);
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule : debounce_sync

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync: default instance plus a SYNC_STAGES=3 / STABLE_CYCLES=2 instance.
module tb_debounce_sync;
    import debounce_pkg::*;

    logic clk;
    logic reset;
    logic d_in, q, rise, fall;
    logic d_in2, q2, rise2, fall2;

    int n_cmp;
    int n_err;

    debounce_sync dut (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .q     (q),
        .rise  (rise),
        .fall  (fall)
    );

    debounce_sync #(
        .SYNC_STAGES   (3),
        .STABLE_CYCLES (2)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in2),
        .q     (q2),
        .rise  (rise2),
        .fall  (fall2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        d_in  = 1'b0;
        d_in2 = 1'b0;
        #12;
        n_cmp++; if (q !== 1'b0)    begin n_err++; $display("FAIL reset_q: got %b expected 0", q); end
        n_cmp++; if (rise !== 1'b0) begin n_err++; $display("FAIL reset_rise: got %b expected 0", rise); end
        n_cmp++; if (fall !== 1'b0) begin n_err++; $display("FAIL reset_fall: got %b expected 0", fall); end
        n_cmp++; if (dut.cnt_q !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", dut.cnt_q); end
        n_cmp++; if (q2 !== 1'b0)   begin n_err++; $display("FAIL reset_q2: got %b expected 0", q2); end
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        n_cmp++; if (q !== 1'b0) begin n_err++; $display("FAIL idle_q: got %b expected 0", q); end
    endtask

    // d_in 0->1 held 10 cycles: q rises after edge 6 with a single rise pulse.
    task automatic test_rise();
        d_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_cmp++; if (q !== (k >= 6)) begin n_err++; $display("FAIL rise_q edge %0d: got %b expected %b", k, q, (k >= 6)); end
            n_cmp++; if (rise !== (k == 6)) begin n_err++; $display("FAIL rise_pulse edge %0d: got %b expected %b", k, rise, (k == 6)); end
            n_cmp++; if (fall !== 1'b0) begin n_err++; $display("FAIL rise_fall edge %0d: got %b expected 0", k, fall); end
        end
    endtask

    // d_in 1->0 held: q falls after edge 6 with a single fall pulse.
    task automatic test_fall();
        d_in = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_cmp++; if (q !== (k < 6)) begin n_err++; $display("FAIL fall_q edge %0d: got %b expected %b", k, q, (k < 6)); end
            n_cmp++; if (fall !== (k == 6)) begin n_err++; $display("FAIL fall_pulse edge %0d: got %b expected %b", k, fall, (k == 6)); end
            n_cmp++; if (rise !== 1'b0) begin n_err++; $display("FAIL fall_rise edge %0d: got %b expected 0", k, rise); end
        end
    endtask

    // Three-cycle glitch is shorter than STABLE_CYCLES and must be ignored.
    task automatic test_glitch();
        for (int k = 1; k <= 10; k++) begin
            d_in = (k <= 3);
            tick();
            n_cmp++; if (q !== 1'b0) begin n_err++; $display("FAIL glitch_q edge %0d: got %b expected 0", k, q); end
            n_cmp++; if (rise !== 1'b0) begin n_err++; $display("FAIL glitch_rise edge %0d: got %b expected 0", k, rise); end
        end
    endtask

    // High 2, low 1, high 8: count restarts, q rises after edge 9 (4 samples after s resumes).
    task automatic test_restart();
        for (int k = 1; k <= 11; k++) begin
            d_in = (k != 3);
            tick();
            n_cmp++; if (q !== (k >= 9)) begin n_err++; $display("FAIL restart_q edge %0d: got %b expected %b", k, q, (k >= 9)); end
            n_cmp++; if (rise !== (k == 9)) begin n_err++; $display("FAIL restart_rise edge %0d: got %b expected %b", k, rise, (k == 9)); end
        end
        d_in = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        n_cmp++; if (q !== 1'b0) begin n_err++; $display("FAIL restart_back_q: got %b expected 0", q); end
    endtask

    // Asynchronous reset mid-count, then d_in=1 across reset release.
    task automatic test_reset_mid();
        d_in = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        n_cmp++; if (dut.state_q !== CHK_HI) begin n_err++; $display("FAIL mid_state: got %0d expected %0d", dut.state_q, CHK_HI); end
        n_cmp++; if (dut.cnt_q !== 3'd2) begin n_err++; $display("FAIL mid_cnt: got %0d expected 2", dut.cnt_q); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (dut.cnt_q !== '0) begin n_err++; $display("FAIL async_cnt: got %0d expected 0", dut.cnt_q); end
        n_cmp++; if (dut.state_q !== IDLE_LO) begin n_err++; $display("FAIL async_state: got %0d expected %0d", dut.state_q, IDLE_LO); end
        n_cmp++; if (q !== 1'b0) begin n_err++; $display("FAIL async_q: got %b expected 0", q); end
        n_cmp++; if (rise !== 1'b0) begin n_err++; $display("FAIL async_rise: got %b expected 0", rise); end
        n_cmp++; if (fall !== 1'b0) begin n_err++; $display("FAIL async_fall: got %b expected 0", fall); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (rise !== 1'b0 || q !== 1'b0) begin n_err++; $display("FAIL held_reset: got q=%b rise=%b expected 0/0", q, rise); end
        end
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++; if (q !== (k >= 6)) begin n_err++; $display("FAIL release_q edge %0d: got %b expected %b", k, q, (k >= 6)); end
            n_cmp++; if (rise !== (k == 6)) begin n_err++; $display("FAIL release_rise edge %0d: got %b expected %b", k, rise, (k == 6)); end
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (q !== 1'b0) begin n_err++; $display("FAIL async_q_high: got %b expected 0", q); end
        n_cmp++; if (fall !== 1'b0) begin n_err++; $display("FAIL async_nofall: got %b expected 0", fall); end
        d_in = 1'b0;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++; if (q !== 1'b0 || fall !== 1'b0) begin n_err++; $display("FAIL post_reset: got q=%b fall=%b expected 0/0", q, fall); end
        end
    endtask

    // Toggling every cycle never settles, with q both low and high.
    task automatic test_toggle();
        for (int k = 1; k <= 20; k++) begin
            d_in2 = k[0];
            tick();
            n_cmp++; if (q2 !== 1'b0 || rise2 !== 1'b0 || fall2 !== 1'b0) begin
                n_err++; $display("FAIL toggle_lo cycle %0d: got q=%b rise=%b fall=%b expected 0/0/0", k, q2, rise2, fall2);
            end
        end
        d_in2 = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        n_cmp++; if (q2 !== 1'b1) begin n_err++; $display("FAIL toggle_settle_q: got %b expected 1", q2); end
        for (int k = 1; k <= 20; k++) begin
            d_in2 = ~k[0];
            tick();
            n_cmp++; if (q2 !== 1'b1 || rise2 !== 1'b0 || fall2 !== 1'b0) begin
                n_err++; $display("FAIL toggle_hi cycle %0d: got q=%b rise=%b fall=%b expected 1/0/0", k, q2, rise2, fall2);
            end
        end
    endtask

    // Edge-count boundary on the small instance: q after exactly 3+2=5 edges.
    task automatic test_small_latency();
        d_in2 = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        n_cmp++; if (q2 !== 1'b0) begin n_err++; $display("FAIL small_low: got %b expected 0", q2); end
        d_in2 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_cmp++; if (q2 !== (k >= 5)) begin n_err++; $display("FAIL small_q edge %0d: got %b expected %b", k, q2, (k >= 5)); end
            n_cmp++; if (rise2 !== (k == 5)) begin n_err++; $display("FAIL small_rise edge %0d: got %b expected %b", k, rise2, (k == 5)); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_rise();
        test_fall();
        test_glitch();
        test_restart();
        test_reset_mid();
        test_toggle();
        test_small_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_debounce_sync
